// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Contents:
//   state_t : FSM state encoding. IDLE=00, BUSY=01, DONE=10.
//             The code 11 is unused and the FSM recovers from it to IDLE.
package seq_shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// n_bit_adder: ripple-carry adder built from binary full-adder (BFA) bit slices.
// Ports:
//   i_a, i_b : W-bit addends
//   i_cin    : carry into bit 0
//   o_sum    : W-bit sum
// There is no carry-out port. Callers that need the carry widen the operands
// by one zero bit, so the carry lands in the top sum bit.
module n_bit_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < W; i++) begin : g_bfa
    assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry[i];
    // The carry out of the top slice has nowhere to go, so it is not built.
    if (i < W - 1) begin : g_carry
      assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: unsigned n x n -> 2n multi-cycle multiplier.
// The multiplier handles one multiplier bit per cycle. It uses a single
// (n+1)-bit ripple adder for the partial sums.
// Ports:
//   i_clk     : clock. All state changes on the rising edge.
//   i_reset   : synchronous, active-high reset. Abandons any operation in flight.
//   i_start   : request. Sampled only in IDLE.
//   i_a, i_b  : multiplicand and multiplier. Captured when i_start is accepted.
//   o_busy    : high for the n cycles of computation.
//   o_done    : one-cycle pulse when o_product becomes valid.
//   o_product : result. Held until the next operation completes.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [n-1:0]   i_a,
  input  logic [n-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*n-1:0] o_product
);

  localparam int CW = $clog2(n + 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [n-1:0]     r_mcand;
  logic [2*n-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [2*n-1:0]   r_product;

  logic [n:0]       w_addA;
  logic [n:0]       w_addB;
  logic [n:0]       w_sum;
  logic [2*n-1:0]   w_shifted;
  logic             w_lastBit;

  // The operands are zero-extended to n+1 bits. The carry is kept in
  // w_sum[n], which becomes the top bit of the accumulator after the shift.
  assign w_addA = {1'b0, r_acc[2*n-1:n]};
  assign w_addB = r_acc[0] ? {1'b0, r_mcand} : '0;

  n_bit_adder #(
    .W(n + 1)
  ) u_adder (
    .i_a  (w_addA),
    .i_b  (w_addB),
    .i_cin(1'b0),
    .o_sum(w_sum)
  );

  // The multiplier bit just used drops off the bottom of the accumulator.
  assign w_shifted = {w_sum, r_acc[n-1:1]};
  assign w_lastBit = (r_cnt == CW'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The outputs are decoded from r_state only. They have no path from the inputs.
  always_comb begin
    w_nextState = IDLE;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: w_nextState = i_start ? BUSY : IDLE;
      BUSY: begin
        o_busy      = 1'b1;
        w_nextState = w_lastBit ? DONE : BUSY;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // o_product is loaded only on the final BUSY cycle. Partial sums never
  // reach the output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mcand <= i_a;
            r_acc   <= {{n{1'b0}}, i_b};
            r_cnt   <= CW'(n);
          end
        end
        BUSY: begin
          r_acc <= w_shifted;
          r_cnt <= r_cnt - CW'(1);
          if (w_lastBit) begin
            r_product <= w_shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier.
// An n=8 instance carries most of the scenarios.
// An n=4 instance covers the narrow-width case.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.n(8)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_product(product)
  );

  seq_shift_add_multiplier #(.n(4)) dut4 (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start4),
    .i_a      (a4),
    .i_b      (b4),
    .o_busy   (busy4),
    .o_done   (done4),
    .o_product(product4)
  );

  // Starts one n=8 multiply from IDLE and waits for done.
  // It then steps one more cycle so the DUT is back in IDLE.
  // latency counts edges from the accepting edge up to done.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               output int latency, output int busyCycles,
                               output bit timedOut);
    a = opA;
    b = opB;
    start = 1'b1;
    latency = 0;
    busyCycles = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      latency++;
      if (busy) busyCycles++;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== 16'd0) begin errors++; $display("[TB] FAIL reset_product: got %0d expected 0", product); end
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_n4: got busy=%b done=%b product=%0d expected 0/0/0", busy4, done4, product4);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc; bit to;
    applyStimulus(8'd3, 8'd5, lat, bc, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
    checks++; if (bc != 8) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc); end
    checks++; if (product !== 16'd15) begin errors++; $display("[TB] FAIL basic_product: got %0d expected 15", product); end
  endtask

  task automatic test_max();
    int lat, bc; bit to;
    applyStimulus(8'd255, 8'd255, lat, bc, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL max_timeout: got no done expected done"); end
    checks++; if (product !== 16'hFE01) begin errors++; $display("[TB] FAIL max_product: got %h expected fe01", product); end
  endtask

  task automatic test_zero();
    int lat, bc; bit to;
    applyStimulus(8'd0, 8'd200, lat, bc, to);
    checks++; if (to || lat != 9) begin errors++; $display("[TB] FAIL zero_a_latency: got %0d (timeout=%0b) expected 9", lat, to); end
    checks++; if (product !== 16'd0) begin errors++; $display("[TB] FAIL zero_a_product: got %0d expected 0", product); end
    applyStimulus(8'd200, 8'd0, lat, bc, to);
    checks++; if (to || lat != 9) begin errors++; $display("[TB] FAIL zero_b_latency: got %0d (timeout=%0b) expected 9", lat, to); end
    checks++; if (product !== 16'd0) begin errors++; $display("[TB] FAIL zero_b_product: got %0d expected 0", product); end
  endtask

  task automatic test_ignored_start();
    int cyc = 0;
    int doneCount = 0;
    a = 8'd7; b = 8'd9; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 3) begin
        start = 1'b1; a = 8'd1; b = 8'd1;
      end
      if (done) begin
        doneCount++;
        checks++; if (product !== 16'd63) begin errors++; $display("[TB] FAIL ignored_product: got %0d expected 63", product); end
        start = 1'b1; a = 8'd1; b = 8'd1;
      end
    end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL ignored_done_count: got %0d expected 1", doneCount); end
    checks++; if (busy !== 1'b0 || product !== 16'd63) begin
      errors++; $display("[TB] FAIL ignored_final: got busy=%b product=%0d expected 0/63", busy, product);
    end
  endtask

  task automatic test_reset_mid_op();
    int doneCount = 0;
    int lat, bc; bit to;
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (product !== 16'd0) begin errors++; $display("[TB] FAIL midreset_product: got %0d expected 0", product); end
    for (int i = 0; i < 12; i++) begin
      if (done) doneCount++;
      @(posedge clk); #1;
    end
    checks++; if (doneCount != 0) begin errors++; $display("[TB] FAIL midreset_done: got %0d pulses expected 0", doneCount); end
    applyStimulus(8'd12, 8'd11, lat, bc, to);
    checks++; if (to || product !== 16'd132) begin errors++; $display("[TB] FAIL midreset_fresh: got %0d (timeout=%0b) expected 132", product, to); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int firstDone = -1;
    int nDone = 0;
    a = 8'd2; b = 8'd3; start = 1'b1;
    for (int i = 0; i < 40 && nDone < 2; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        nDone++;
        if (nDone == 1) begin
          firstDone = cyc;
          checks++; if (product !== 16'd6) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 6", product); end
          a = 8'd4; b = 8'd5;
        end else begin
          checks++; if (product !== 16'd20) begin errors++; $display("[TB] FAIL b2b_second: got %0d expected 20", product); end
          checks++; if (cyc - firstDone != 10) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 10", cyc - firstDone); end
        end
      end
    end
    start = 1'b0;
    checks++; if (nDone != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", nDone); end
    @(posedge clk); #1;
  endtask

  task automatic test_n4();
    int lat = 0;
    bit to = 1'b1;
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      lat++;
      if (done4) begin to = 1'b0; break; end
    end
    checks++; if (to || lat != 5) begin errors++; $display("[TB] FAIL n4_latency: got %0d (timeout=%0b) expected 5", lat, to); end
    checks++; if (product4 !== 8'd225) begin errors++; $display("[TB] FAIL n4_product: got %0d expected 225", product4); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, bc; bit to;
    logic [7:0] ra, rb;
    logic [15:0] expected;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      expected = 16'(ra) * 16'(rb);
      applyStimulus(ra, rb, lat, bc, to);
      checks++;
      if (to || product !== expected) begin
        errors++;
        $display("[TB] FAIL random_%0d: %0d*%0d got %0d (timeout=%0b) expected %0d", k, ra, rb, product, to, expected);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    test_n4();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
